// File: rtl/next_pc_bp.sv
// Fetch PC register with direct-mapped BTB and saturating direction counters.
// Predicts the next fetch PC, takes decode-stage jumps, and redirects on
// branch mispredicts resolved downstream (held pending across stalls).
// Optional macro BP_STATS_EN adds branch / mispredict event counters.

package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

module next_pc_bp
    import cpu_types_pkg::*;
#(
    parameter int    BTB_ENTRIES = 16,
    parameter int    CTR_BITS    = 2,
    parameter word_t PC_RESET    = 32'h0
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  stall,
    input  logic  jump,
    input  word_t jump_addr,
    input  logic  jump_reg,
    input  word_t rdat1,
    input  logic  resolve_valid,
    input  word_t resolve_pc,
    input  logic  resolve_taken,
    input  word_t resolve_target,
    input  logic  resolve_pred_taken,
    input  word_t resolve_pred_target,
    output word_t pc,
    output word_t pc4,
    output logic  pred_taken,
    output word_t pred_target,
    output logic  mispredict
`ifdef BP_STATS_EN
    ,
    output word_t stat_branches,
    output word_t stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        word_t               target;
        logic [CTR_BITS-1:0] ctr;
    } btb_ent_t;

    btb_ent_t               btb [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_vld;

    logic        pend_vld;
    word_t       pend_addr;
    word_t       redirect;
    word_t       pc_next;

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    assign lk_idx = pc[IDX+1:2];
    assign lk_tag = pc[31:IDX+2];
    assign up_idx = resolve_pc[IDX+1:2];
    assign up_tag = resolve_pc[31:IDX+2];

    // Lookup sees registered BTB contents, so a same-cycle update is not visible yet
    always_comb begin
        lk_hit      = btb_vld[lk_idx] && (btb[lk_idx].tag == lk_tag);
        up_hit      = btb_vld[up_idx] && (btb[up_idx].tag == up_tag);
        pred_taken  = lk_hit && btb[lk_idx].ctr[CTR_BITS-1];
        pred_target = pred_taken ? btb[lk_idx].target : '0;
    end

    // Mispredict detection and recovery address
    always_comb begin
        mispredict = resolve_valid &&
                     ((resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && (resolve_target != resolve_pred_target)));
        redirect   = resolve_taken ? resolve_target : resolve_pc + 32'd4;
    end

    assign pc4 = pc + 32'd4;

    // Next-PC priority when not redirecting: JR, J/JAL, prediction, sequential
    always_comb begin
        pc_next = pc4;
        if (jump_reg)        pc_next = rdat1;
        else if (jump)       pc_next = jump_addr;
        else if (pred_taken) pc_next = pred_target;
    end

    // Fetch PC and pending redirect; a stalled mispredict is parked until release
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc        <= PC_RESET;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else if (mispredict) begin
            if (stall) begin
                pend_vld  <= 1'b1;
                pend_addr <= redirect;
            end else begin
                pc       <= redirect;
                pend_vld <= 1'b0;
            end
        end else if (!stall) begin
            pend_vld <= 1'b0;
            pc       <= pend_vld ? pend_addr : pc_next;
        end
    end

    // Valid bits are the only BTB state that needs reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            btb_vld <= '0;
        else if (resolve_valid && !up_hit && resolve_taken)
            btb_vld[up_idx] <= 1'b1;
    end

    // Entry training: saturating counter on hit, weakly-taken allocate on taken miss
    always_ff @(posedge CLK) begin
        if (resolve_valid) begin
            if (up_hit) begin
                if (resolve_taken) begin
                    btb[up_idx].target <= resolve_target;
                    if (btb[up_idx].ctr != CTR_MAX)
                        btb[up_idx].ctr <= btb[up_idx].ctr + 1'b1;
                end else if (btb[up_idx].ctr != '0) begin
                    btb[up_idx].ctr <= btb[up_idx].ctr - 1'b1;
                end
            end else if (resolve_taken) begin
                btb[up_idx].tag    <= up_tag;
                btb[up_idx].target <= resolve_target;
                btb[up_idx].ctr    <= CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    // Saturating event counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve_valid && (stat_branches != '1))
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/next_pc_bp.md
Name: next_pc_bp

Overview:
- Parametrised successor to the combinational next-PC selector; owns the fetch PC register and adds a direct-mapped branch target buffer (BTB) with saturating direction counters.
- Predicts next fetch PC in IF, accepts decode-stage jumps, and detects and recovers from branch mispredicts resolved downstream.
- Sits between the hazard unit, the IF stage and the branch-resolve stage of the pipelined datapath.
- All addresses are word_t (32 bit) from cpu_types_pkg.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, 2 to 256.
CTR_BITS, 2, width of each saturating direction counter; 1 to 4.
PC_RESET, 32'h0, fetch PC value after reset.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
stall  in  1  hold fetch PC; from hazard unit.
jump  in  1  J/JAL in decode.
jump_addr  in  32  J/JAL target.
jump_reg  in  1  JR in decode.
rdat1  in  32  JR target (register read data).
resolve_valid  in  1  one-cycle pulse per resolved conditional branch.
resolve_pc  in  32  PC of the resolved branch.
resolve_taken  in  1  actual direction.
resolve_target  in  32  actual taken target.
resolve_pred_taken  in  1  prediction carried down the pipe with the branch.
resolve_pred_target  in  32  predicted target carried down the pipe.
pc  out  32  current fetch PC.
pc4  out  32  pc + 4.
pred_taken  out  1  BTB prediction for pc.
pred_target  out  32  BTB target for pc; 0 when pred_taken = 0.
mispredict  out  1  combinational flush request to hazard unit.

Behaviour:
- Reset (async, nRST low):
  - pc = PC_RESET.
  - All BTB valid bits cleared.
  - Pending-redirect register cleared.
  - Outputs: pred_taken = 0, pred_target = 0, mispredict = 0, pc4 = PC_RESET + 4.
  - Reset mid-operation discards any pending redirect.
- Indexing: IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2]. Tag = pc[31:IDX+2]. pc[1:0] ignored.
- Lookup (combinational on pc):
  - hit = valid & tag match.
  - pred_taken = hit & counter MSB set.
  - pred_target = stored target when pred_taken, else 0.
- Mispredict (combinational):
  - mispredict = resolve_valid & (resolve_taken != resolve_pred_taken | (resolve_taken & resolve_target != resolve_pred_target)).
  - Redirect address = resolve_taken ? resolve_target : resolve_pc + 4.
- Next-PC priority, evaluated each rising edge:
  1. Mispredict, or pending redirect if no new mispredict.
  2. jump_reg -> rdat1.
  3. jump -> jump_addr.
  4. pred_taken -> pred_target.
  5. Otherwise pc4.
- Stall handling:
  - stall = 1: pc holds.
  - A mispredict while stalled loads the pending register with the redirect address.
  - The first cycle with stall = 0 loads pc from the pending register and clears it.
  - A newer mispredict overwrites pending.
  - Mispredict outranks jump/jump_reg in the same cycle (decode is being flushed).
- Latency:
  - Unstalled redirect appears on pc one cycle after mispredict.
  - BTB update is visible to lookup the cycle after resolve_valid.
- BTB update on resolve_valid (independent of stall), indexed by resolve_pc:
  - Hit:
    - Counter saturating-increments if taken, saturating-decrements if not.
    - Target overwritten if taken.
  - Miss and taken:
    - Allocate: valid = 1, write tag and target.
    - Counter = 2^(CTR_BITS-1), i.e. weakly taken.
  - Miss and not taken: no change.
  - Counters never wrap past 0 or 2^CTR_BITS - 1.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents.
- Arithmetic: pc + 4 and resolve_pc + 4 are modulo 2^32; 32'hFFFFFFFC wraps to 0.

Optional Feature:
BP_STATS_EN
- Defined:
  - Adds output ports stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every resolve_valid; stat_mispredicts increments on every mispredict.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with PC_RESET = 0, then 4 unstalled cycles -> pc = 0, 4, 8, 12, 16; pred_taken = 0 throughout.
- Resolve taken branch resolve_pc = 0x20, target 0x100, pred_taken = 0 -> mispredict = 1. Next cycle pc = 0x100 and entry allocated weakly taken. Later fetch of 0x20 -> pred_taken = 1, pred_target = 0x100.
- Branch at 0x20 resolved not-taken twice with correct-prediction fields -> counter 2 -> 1 -> 0. Third fetch of 0x20 gives pred_taken = 0. A further not-taken resolve holds the counter at 0.
- Mispredict (redirect 0x200) while stall = 1 for 3 cycles -> pc unchanged during the stall; pc = 0x200 on the first unstalled edge. A jump asserted in the mispredict cycle is ignored.
- jump_reg = 1, rdat1 = 0x400, jump = 1, jump_addr = 0x300, pc predicted taken -> pc = 0x400.
- With BP_STATS_EN: 5 resolves, 2 of them mispredicted -> stat_branches = 5, stat_mispredicts = 2. nRST low clears both.
